mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_pkg.sv | 24 ++
 rtl/mem_access_ctrl_if.sv | 34 +++
 rtl/mem_access_ctrl.sv | 101 ++++++++++
 tb/tb_mem_access_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types for the memory access controller: request opcodes and FSM states.
// ST_INIT exists only when MEM_ACCESS_CTRL_INIT_EN is defined.
package mem_access_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_ADD   = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR     = 3'd1,
        ST_RD     = 3'd2,
        ST_CAP    = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_RSP    = 3'd5
`ifdef MEM_ACCESS_CTRL_INIT_EN
        , ST_INIT = 3'd6
`endif
    } state_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response and synchronous-memory bus of the memory access controller.
// slave = controller side; master = requester plus memory model side.
interface mem_access_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6
);
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_op;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic                  mem_re;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  idle;

    modport slave (
        input  req_valid, req_op, req_addr, req_data, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        output mem_addr, mem_we, mem_re, mem_wdata, idle
    );

    modport master (
        output req_valid, req_op, req_addr, req_data, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        input  mem_addr, mem_we, mem_re, mem_wdata, idle
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-outstanding READ/WRITE/ADD controller in front of a 1-cycle synchronous memory.
// Define MEM_ACCESS_CTRL_INIT_EN to zero-fill the memory after reset before accepting requests.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input logic              clk,
    input logic              rst,
    mem_access_ctrl_if.slave bus
);

    state_e state;
    state_e next_state;
    op_e    op_q;
    op_e    req_op;
    logic   accept;
    logic   addr_ok;
    logic   req_err;

    assign req_op  = op_e'(bus.req_op);
    assign accept  = bus.req_valid && (state == ST_IDLE);
    assign addr_ok = ({1'b0, bus.req_addr} < (ADDR_WIDTH+1)'(DEPTH));
    assign req_err = (req_op == OP_RSVD) || ((req_op != OP_WRITE) && !addr_ok);

    // Handshake and strobe outputs are pure decodes of the state register.
    assign bus.req_ready = (state == ST_IDLE);
    assign bus.idle      = (state == ST_IDLE);
    assign bus.rsp_valid = (state == ST_RSP);
    assign bus.mem_re    = (state == ST_RD);
`ifdef MEM_ACCESS_CTRL_INIT_EN
    assign bus.mem_we    = (state == ST_WR) || (state == ST_RMW_WR) || (state == ST_INIT);
`else
    assign bus.mem_we    = (state == ST_WR) || (state == ST_RMW_WR);
`endif

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (req_err)                 next_state = ST_RSP;
                    else if (req_op == OP_WRITE) next_state = addr_ok ? ST_WR : ST_IDLE;
                    else                         next_state = ST_RD;
                end
            end
            ST_WR:     next_state = ST_IDLE;
            ST_RD:     next_state = ST_CAP;
            ST_CAP:    next_state = (op_q == OP_ADD) ? ST_RMW_WR : ST_RSP;
            ST_RMW_WR: next_state = ST_RSP;
            ST_RSP:    next_state = bus.rsp_ready ? ST_IDLE : ST_RSP;
`ifdef MEM_ACCESS_CTRL_INIT_EN
            ST_INIT:   next_state = (bus.mem_addr == ADDR_WIDTH'(DEPTH - 1)) ? ST_IDLE : ST_INIT;
`endif
            default:   next_state = ST_IDLE;
        endcase
    end

    // State and datapath registers; mem_addr doubles as the fill pointer during INIT.
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef MEM_ACCESS_CTRL_INIT_EN
            state         <= ST_INIT;
`else
            state         <= ST_IDLE;
`endif
            op_q          <= OP_READ;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q          <= req_op;
                        bus.mem_addr  <= bus.req_addr;
                        bus.mem_wdata <= bus.req_data;
                        bus.rsp_data  <= '0;
                        bus.rsp_err   <= req_err;
                    end
                end
                ST_CAP: begin
                    bus.rsp_data <= bus.mem_rdata;
                    if (op_q == OP_ADD) begin
                        bus.mem_wdata <= DATA_WIDTH'(bus.mem_rdata + bus.mem_wdata);
                    end
                end
`ifdef MEM_ACCESS_CTRL_INIT_EN
                ST_INIT: bus.mem_addr <= ADDR_WIDTH'(bus.mem_addr + ADDR_WIDTH'(1));
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl paired with a 1-cycle synchronous memory model.
// Covers MEM_ACCESS_CTRL_INIT_EN fill sequence when that macro is defined.
module tb_mem_access_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   we_count;
    logic [7:0] mem [64];

    mem_access_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) bus ();

    mem_access_ctrl #(.DATA_WIDTH(8), .DEPTH(32), .ADDR_WIDTH(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: read data appears the cycle after mem_re.
    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            we_count          <= we_count + 1;
        end
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and return at the cycle after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [5:0] addr, input logic [7:0] data);
        int n;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_data  = data;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            tick();
            n++;
        end
        if (!bus.req_ready) check("accept_timeout", 32'd0, 32'd1);
        tick();
        bus.req_valid = 1'b0;
    endtask

    // Latency counted from the accept cycle; returns 99 on timeout.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!bus.rsp_valid) lat = 99;
    endtask

    task automatic consume();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int we_snap;
        n_checks      = 0;
        n_pass        = 0;
        we_count      = 0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'd0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b0;
        bus.mem_rdata = '0;
        tick();
        tick();

        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
        check("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
        check("rst_mem_re",    32'(bus.mem_re),    32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        rst = 1'b0;

`ifdef MEM_ACCESS_CTRL_INIT_EN
        for (int i = 0; i < 32; i++) begin
            check("init_we",    32'(bus.mem_we),    32'd1);
            check("init_addr",  32'(bus.mem_addr),  32'(i));
            check("init_wdata", 32'(bus.mem_wdata), 32'd0);
            check("init_busy",  32'(bus.req_ready | bus.idle), 32'd0);
            tick();
        end
        check("init_done_ready", 32'(bus.req_ready), 32'd1);
        issue(2'd0, 6'd31, 8'h00);
        wait_rsp(lat);
        check("init_rd31_data", 32'(bus.rsp_data), 32'h00);
        consume();
`else
        check("post_rst_ready", 32'(bus.req_ready), 32'd1);
        check("post_rst_idle",  32'(bus.idle),      32'd1);
        check("post_rst_we",    32'(bus.mem_we),    32'd0);
`endif

        // WRITE 5 <- A5, READ 5
        issue(2'd1, 6'd5, 8'hA5);
        check("wr5_we",    32'(bus.mem_we),    32'd1);
        check("wr5_addr",  32'(bus.mem_addr),  32'd5);
        check("wr5_wdata", 32'(bus.mem_wdata), 32'hA5);
        tick();
        check("wr5_idle", 32'(bus.idle), 32'd1);
        issue(2'd0, 6'd5, 8'h00);
        wait_rsp(lat);
        check("rd5_latency", 32'(lat), 32'd3);
        check("rd5_data",    32'(bus.rsp_data), 32'hA5);
        check("rd5_err",     32'(bus.rsp_err),  32'd0);
        consume();
        check("rd5_ready_after", 32'(bus.req_ready), 32'd1);

        // WRITE 7 <- F0, ADD 7 += 20 (wraps to 10)
        issue(2'd1, 6'd7, 8'hF0);
        tick();
        issue(2'd2, 6'd7, 8'h20);
        wait_rsp(lat);
        check("add7_latency", 32'(lat), 32'd4);
        check("add7_old",     32'(bus.rsp_data), 32'hF0);
        check("add7_err",     32'(bus.rsp_err),  32'd0);
        consume();
        issue(2'd0, 6'd7, 8'h00);
        wait_rsp(lat);
        check("rd7_wrap", 32'(bus.rsp_data), 32'h10);
        consume();

        // Out-of-range READ, reserved op, dropped out-of-range WRITE
        issue(2'd0, 6'd40, 8'h00);
        wait_rsp(lat);
        check("rd40_latency", 32'(lat), 32'd1);
        check("rd40_err",     32'(bus.rsp_err),  32'd1);
        check("rd40_data",    32'(bus.rsp_data), 32'd0);
        consume();
        issue(2'd3, 6'd2, 8'h00);
        wait_rsp(lat);
        check("rsvd_latency", 32'(lat), 32'd1);
        check("rsvd_err",     32'(bus.rsp_err), 32'd1);
        consume();
        we_snap = we_count;
        issue(2'd1, 6'd40, 8'h55);
        check("wr40_no_we", 32'(bus.mem_we), 32'd0);
        check("wr40_idle",  32'(bus.idle),   32'd1);
        tick();
        tick();
        check("wr40_no_rsp",   32'(bus.rsp_valid), 32'd0);
        check("wr40_we_count", 32'(we_count),      32'(we_snap));

        // Backpressure: response held while rsp_ready is low
        issue(2'd1, 6'd9, 8'h3C);
        tick();
        issue(2'd0, 6'd9, 8'h00);
        wait_rsp(lat);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_data",  32'(bus.rsp_data),  32'h3C);
            check("bp_ready", 32'(bus.req_ready), 32'd0);
            tick();
        end
        consume();
        check("bp_next_accept", 32'(bus.req_ready), 32'd1);

        // Reset during CAP of an ADD aborts the write-back
        issue(2'd1, 6'd3, 8'h11);
        tick();
        we_snap = we_count;
        issue(2'd2, 6'd3, 8'h05);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
`ifndef MEM_ACCESS_CTRL_INIT_EN
        check("abort_idle",  32'(bus.idle),      32'd1);
        check("abort_no_we", 32'(bus.mem_we),    32'd0);
        check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
        tick();
        tick();
        check("abort_we_count", 32'(we_count), 32'(we_snap));
        issue(2'd0, 6'd3, 8'h00);
        wait_rsp(lat);
        check("abort_rd3", 32'(bus.rsp_data), 32'h11);
        consume();
`else
        check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
        for (int i = 0; i < 40; i++) if (!bus.req_ready) tick();
        check("abort_init_done", 32'(bus.req_ready), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
